// File: rtl/smartpark_pkg.sv
// Shared types and constants for the smart-park drive sequencer.
package smartpark_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CRUISE   = 3'd1,
    SLOT_CHK = 3'd2,
    STOP1    = 3'd3,
    REVERSE  = 3'd4,
    STOP2    = 3'd5,
    PARKED   = 3'd6
  } state_t;

  localparam logic [1:0] PARK_TRACK   = 2'b00;
  localparam logic [1:0] PARK_SEARCH  = 2'b01;
  localparam logic [1:0] PARK_REVERSE = 2'b10;
  localparam logic [1:0] PARK_HOLD    = 2'b11;

  localparam logic [4:0] TURN_LOST     = 5'b00000;
  localparam logic [4:0] TURN_STOPLINE = 5'b11111;

  typedef struct packed {
    logic       pwm_en;
    logic [1:0] park;
    logic       reverse;
    logic       busy;
    logic       done;
  } drive_t;

  // Moore output decode; reverse is only set in states bracketed by pwm_en=0 stops
  function automatic drive_t drive_of(input state_t s);
    drive_t d;
    case (s)
      IDLE:     d = '{pwm_en: 1'b0, park: PARK_TRACK,   reverse: 1'b0, busy: 1'b0, done: 1'b0};
      CRUISE:   d = '{pwm_en: 1'b1, park: PARK_TRACK,   reverse: 1'b0, busy: 1'b1, done: 1'b0};
      SLOT_CHK: d = '{pwm_en: 1'b1, park: PARK_SEARCH,  reverse: 1'b0, busy: 1'b1, done: 1'b0};
      STOP1:    d = '{pwm_en: 1'b0, park: PARK_SEARCH,  reverse: 1'b0, busy: 1'b1, done: 1'b0};
      REVERSE:  d = '{pwm_en: 1'b1, park: PARK_REVERSE, reverse: 1'b1, busy: 1'b1, done: 1'b0};
      STOP2:    d = '{pwm_en: 1'b0, park: PARK_REVERSE, reverse: 1'b1, busy: 1'b1, done: 1'b0};
      PARKED:   d = '{pwm_en: 1'b0, park: PARK_HOLD,    reverse: 1'b0, busy: 1'b0, done: 1'b1};
      default:  d = '{pwm_en: 1'b0, park: PARK_TRACK,   reverse: 1'b0, busy: 1'b0, done: 1'b0};
    endcase
    return d;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/park_sequencer_tick_gen.sv
// Free-running divider producing a one-clk tick every TICK_DIV cycles,
// so phase lengths stay in milliseconds regardless of clk frequency.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // wrap at TICK_DIV-1; tick is the decode of that count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/park_sequencer.sv
// Drive sequencer: cruise, free-slot qualification, stop, reverse-in, parked.
// Outputs are registered from next-state so they move on the same edge as the state.
module park_sequencer
  import smartpark_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned SLOT_MS  = 300,
  parameter int unsigned STOP_MS  = 500,
  parameter int unsigned REV_MS   = 1500,
  parameter int unsigned LOST_MS  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] turn,
  input  logic       slot_free,
  output logic       pwm_en,
  output logic [1:0] park,
  output logic       reverse,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int unsigned PH_MAX = max3(SLOT_MS, STOP_MS, REV_MS);
  localparam int unsigned PW     = $clog2(PH_MAX + 1);
  localparam int unsigned LW     = $clog2(LOST_MS + 1);

  localparam logic [PW-1:0] SLOT_LAST = PW'(SLOT_MS - 1);
  localparam logic [PW-1:0] STOP_LAST = PW'(STOP_MS - 1);
  localparam logic [PW-1:0] REV_LAST  = PW'(REV_MS - 1);
  localparam logic [PW-1:0] PH_SAT    = PW'(PH_MAX);
  localparam logic [LW-1:0] LOST_LAST = LW'(LOST_MS - 1);
  localparam logic [LW-1:0] LOST_SAT  = LW'(LOST_MS);

  logic          tick_s;
  state_t        state_r;
  state_t        state_nx_s;
  logic [PW-1:0] ph_r;
  logic [PW-1:0] ph_nx_s;
  logic [LW-1:0] lost_r;
  logic [LW-1:0] lost_nx_s;
  logic          fault_nx_s;
  logic          line_lost_s;
  drive_t        drv_nx_s;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_s)
  );

  assign line_lost_s = (turn == TURN_LOST);

  // next-state, sticky fault and counter updates; abort outranks every other exit
  always_comb begin
    state_nx_s = state_r;
    fault_nx_s = fault;
    if (abort) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nx_s = CRUISE;
            fault_nx_s = 1'b0;
          end else begin
            state_nx_s = IDLE;
          end
        end
        CRUISE: begin
          if (tick_s && line_lost_s && (lost_r == LOST_LAST)) begin
            state_nx_s = IDLE;
            fault_nx_s = 1'b1;
          end else if (slot_free) begin
            state_nx_s = SLOT_CHK;
          end else begin
            state_nx_s = CRUISE;
          end
        end
        SLOT_CHK: begin
          if (!slot_free) begin
            state_nx_s = CRUISE;
          end else if (tick_s && (ph_r == SLOT_LAST)) begin
            state_nx_s = STOP1;
          end else begin
            state_nx_s = SLOT_CHK;
          end
        end
        STOP1: begin
          if (tick_s && (ph_r == STOP_LAST)) begin
            state_nx_s = REVERSE;
          end else begin
            state_nx_s = STOP1;
          end
        end
        REVERSE: begin
          if ((turn == TURN_STOPLINE) || (tick_s && (ph_r == REV_LAST))) begin
            state_nx_s = STOP2;
          end else begin
            state_nx_s = REVERSE;
          end
        end
        STOP2: begin
          if (tick_s && (ph_r == STOP_LAST)) begin
            state_nx_s = PARKED;
          end else begin
            state_nx_s = STOP2;
          end
        end
        PARKED: begin
          if (start) begin
            state_nx_s = CRUISE;
          end else begin
            state_nx_s = PARKED;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end

    if (state_nx_s != state_r) begin
      ph_nx_s = '0;
    end else if (tick_s && (ph_r != PH_SAT)) begin
      ph_nx_s = ph_r + PW'(1);
    end else begin
      ph_nx_s = ph_r;
    end

    // lost count only accumulates while staying in CRUISE with no line seen
    if ((state_r != CRUISE) || (state_nx_s != CRUISE) || !line_lost_s) begin
      lost_nx_s = '0;
    end else if (tick_s && (lost_r != LOST_SAT)) begin
      lost_nx_s = lost_r + LW'(1);
    end else begin
      lost_nx_s = lost_r;
    end

    drv_nx_s = drive_of(state_nx_s);
  end

  // state, counters and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ph_r    <= '0;
      lost_r  <= '0;
      fault   <= 1'b0;
      pwm_en  <= 1'b0;
      park    <= PARK_TRACK;
      reverse <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ph_r    <= ph_nx_s;
      lost_r  <= lost_nx_s;
      fault   <= fault_nx_s;
      pwm_en  <= drv_nx_s.pwm_en;
      park    <= drv_nx_s.park;
      reverse <= drv_nx_s.reverse;
      busy    <= drv_nx_s.busy;
      done    <= drv_nx_s.done;
    end
  end

endmodule
